// File: rtl/bullet_scheduler.sv
// bullet_scheduler: owns the BulletBill slots, spawns a bullet on a fire request,
// advances live bullets once per STEP_FRAMES vblanks and turns DDAVER hits into kill requests.
module bullet_scheduler #(
  parameter int unsigned NUM_BULLETS = 3,
  parameter int unsigned ENEMY_ROWS  = 5,
  parameter int unsigned ENEMY_COLS  = 6,
  parameter logic [3:0]  SPAWN_Y     = 4'd11,
  parameter int unsigned STEP_FRAMES = 2
) (
  input  logic                   vgaclk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   fire,
  input  logic [11:0]            fire_color,
  input  logic [3:0]             blockieee,
  input  logic [11:0]            ddavers [0:ENEMY_ROWS-1][0:ENEMY_COLS-1],
  output logic [11:0]            bulletBillColor [0:NUM_BULLETS-1],
  output logic [3:0]             bulletBillXLoc  [0:NUM_BULLETS-1],
  output logic [3:0]             bulletBillYLoc  [0:NUM_BULLETS-1],
  output logic [NUM_BULLETS-1:0] bullet_active,
  output logic                   kill_valid,
  output logic [2:0]             kill_row,
  output logic [2:0]             kill_col,
  output logic                   fire_drop,
  output logic                   frame_overrun
);

  localparam int unsigned IDX_W  = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int unsigned CNT_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int unsigned CELLS  = ENEMY_ROWS * ENEMY_COLS;
  localparam int unsigned KILL_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_move;
  logic [CNT_W-1:0]       r_step;
  logic                   r_pending;
  logic [11:0]            r_pcolor;
  logic [3:0]             r_px;
  logic [CELLS-1:0]       r_killed;
  logic [11:0]            r_color [0:NUM_BULLETS-1];
  logic [3:0]             r_x     [0:NUM_BULLETS-1];
  logic [3:0]             r_y     [0:NUM_BULLETS-1];
  logic [NUM_BULLETS-1:0] r_active;
  logic                   r_kill_valid;
  logic [2:0]             r_kill_row;
  logic [2:0]             r_kill_col;
  logic                   r_fire_drop;
  logic                   r_overrun;

  logic                   w_cur_active;
  logic [11:0]            w_cur_color;
  logic [3:0]             w_cur_x;
  logic [3:0]             w_cur_y;
  logic [3:0]             w_new_y;
  logic [11:0]            w_cell;
  logic [KILL_W-1:0]      w_cell_idx;
  logic                   w_in_grid;
  logic                   w_blocked;
  logic                   w_free_found;
  logic [IDX_W-1:0]       w_free_idx;

  always_comb begin
    w_cur_active = 1'b0;
    w_cur_color  = '0;
    w_cur_x      = '0;
    w_cur_y      = '0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_active = r_active[i];
        w_cur_color  = r_color[i];
        w_cur_x      = r_x[i];
        w_cur_y      = r_y[i];
      end
    end
    w_new_y = w_cur_y - 4'd1;
  end

  // A cell killed earlier in this scan still shows in ddavers; treat it as empty.
  always_comb begin
    w_cell     = '0;
    w_cell_idx = '0;
    w_in_grid  = 1'b0;
    for (int r = 0; r < int'(ENEMY_ROWS); r++) begin
      for (int c = 0; c < int'(ENEMY_COLS); c++) begin
        if (w_new_y == 4'(r) && w_cur_x == 4'(c)) begin
          w_cell     = ddavers[r][c];
          w_cell_idx = KILL_W'(r * int'(ENEMY_COLS) + c);
          w_in_grid  = 1'b1;
        end
      end
    end
    w_blocked = w_in_grid && (w_cell != 12'h000) && !r_killed[w_cell_idx];
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = int'(NUM_BULLETS) - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_move       <= 1'b0;
      r_step       <= '0;
      r_pending    <= 1'b0;
      r_pcolor     <= '0;
      r_px         <= '0;
      r_killed     <= '0;
      r_active     <= '0;
      r_kill_valid <= 1'b0;
      r_kill_row   <= '0;
      r_kill_col   <= '0;
      r_fire_drop  <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        r_color[i] <= '0;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
      end
    end else begin
      r_kill_valid <= 1'b0;
      r_fire_drop  <= 1'b0;
      r_overrun    <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (frame_tick) begin
            r_state  <= StScan;
            r_idx    <= '0;
            r_killed <= '0;
            r_move   <= (r_step == CNT_W'(STEP_FRAMES - 1));
            if (r_step == CNT_W'(STEP_FRAMES - 1)) begin
              r_step <= '0;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end else if (r_pending) begin
            r_pending <= 1'b0;
            if (w_free_found) begin
              r_active[w_free_idx] <= 1'b1;
              r_color[w_free_idx]  <= r_pcolor;
              r_x[w_free_idx]      <= r_px;
              r_y[w_free_idx]      <= SPAWN_Y;
            end else begin
              r_fire_drop <= 1'b1;
            end
          end
        end

        StScan: begin
          if (r_move && w_cur_active) begin
            if (w_cur_y == 4'd0 || w_blocked) begin
              r_active[r_idx] <= 1'b0;
              r_color[r_idx]  <= '0;
              r_x[r_idx]      <= '0;
              r_y[r_idx]      <= '0;
              if (w_cur_y != 4'd0 && w_cell == w_cur_color) begin
                r_kill_valid         <= 1'b1;
                r_kill_row           <= w_new_y[2:0];
                r_kill_col           <= w_cur_x[2:0];
                r_killed[w_cell_idx] <= 1'b1;
              end
            end else begin
              r_y[r_idx] <= w_new_y;
            end
          end
          if (r_idx == IDX_W'(NUM_BULLETS - 1)) begin
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        StDone: r_state <= StIdle;

        default: r_state <= StIdle;
      endcase

      if (frame_tick && r_state != StIdle) begin
        r_overrun <= 1'b1;
      end

      // A new request arriving while the old one is serviced stays pending.
      if (fire) begin
        r_pending <= 1'b1;
        r_pcolor  <= fire_color;
        r_px      <= blockieee;
      end
    end
  end

  assign bulletBillColor = r_color;
  assign bulletBillXLoc  = r_x;
  assign bulletBillYLoc  = r_y;
  assign bullet_active   = r_active;
  assign kill_valid      = r_kill_valid;
  assign kill_row        = r_kill_row;
  assign kill_col        = r_kill_col;
  assign fire_drop       = r_fire_drop;
  assign frame_overrun   = r_overrun;

endmodule
